mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single unified instruction/data memory of the multicycle MIPS datapath. It shares the memory between two requesters: the CPU datapath port, driven by the main controller's IorD / R_wbar access steps, and the debug/loader port used to preload programs and inspect memory. It owns the variable-latency memory handshake, stalls the CPU while its access is pending, and aborts accesses that never complete.

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester and memory signals around mem_port_arbiter.
//   cpu_* : CPU datapath port (req/rwbar/addr/wdata in, rdata/ack/stall out)
//   dbg_* : debug/loader port, same semantics minus stall
//   mem_* : variable-latency memory port (req/rwbar/addr/wdata out, rdata/ready in)
//   timeout_err : sticky flag raised when a memory access never completed
// Modport slave is the arbiter's view; master is the environment's view
// (requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              cpu_req;
  logic              cpu_rwbar;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_rwbar;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_req;
  logic              mem_rwbar;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              timeout_err;

  modport slave (
    input  cpu_req, cpu_rwbar, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_req, dbg_rwbar, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_req, mem_rwbar, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output timeout_err
  );

  modport master (
    output cpu_req, cpu_rwbar, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dbg_req, dbg_rwbar, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_req, mem_rwbar, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the unified instruction/data memory of the
// multicycle MIPS datapath. Two requesters (CPU datapath, debug/loader) share
// one variable-latency memory; ownership alternates round-robin on ties.
// Each access runs IDLE -> ACCESS -> RESP. An access with no mem_ready within
// MAX_WAIT cycles is aborted: the owner gets all-ones data and timeout_err
// latches until RESET.
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   RESET : synchronous, active-high reset
//   bus   : mem_port_arbiter_if.slave (cpu_*, dbg_*, mem_*, timeout_err)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned     CntW    = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic {OwnCpu = 1'b0, OwnDbg = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_rwbar_q, mem_rwbar_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              timeout_q, timeout_d;

  logic              grant_dbg;
  logic              resp_load;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_rwbar_d  = mem_rwbar_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    timeout_d    = timeout_q;
    grant_dbg    = 1'b0;
    resp_load    = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req || bus.dbg_req) begin
          // On a tie the port that was not served last wins.
          grant_dbg = bus.dbg_req && (!bus.cpu_req || (last_owner_q == OwnCpu));
          owner_d   = grant_dbg ? OwnDbg : OwnCpu;
          if (grant_dbg) begin
            mem_rwbar_d = bus.dbg_rwbar;
            mem_addr_d  = bus.dbg_addr;
            mem_wdata_d = bus.dbg_wdata;
          end else begin
            mem_rwbar_d = bus.cpu_rwbar;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
          end
          cnt_d   = '0;
          state_d = StAccess;
        end
      end

      StAccess: begin
        if (bus.mem_ready) begin
          resp_load = 1'b1;
          resp_data = mem_rwbar_q ? bus.mem_rdata : '0;
          state_d   = StResp;
        end else begin
          // Saturate so the counter can never wrap back into range.
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if (cnt_q == CntLast) begin
            timeout_d = 1'b1;
            resp_load = 1'b1;
            resp_data = '1;
            state_d   = StResp;
          end
        end
      end

      StResp: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (resp_load) begin
      if (owner_q == OwnDbg) begin
        dbg_rdata_d = resp_data;
      end else begin
        cpu_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      last_owner_q <= OwnDbg;
      cnt_q        <= '0;
      mem_rwbar_q  <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_rwbar_q  <= mem_rwbar_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.mem_req     = (state_q == StAccess);
  assign bus.mem_rwbar   = mem_rwbar_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.cpu_ack     = (state_q == StResp) && (owner_q == OwnCpu);
  assign bus.dbg_ack     = (state_q == StResp) && (owner_q == OwnDbg);
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.cpu_stall   = bus.cpu_req & ~bus.cpu_ack;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized two-port
// phase. Requesters push expected responses into per-port queues; a monitor
// pops and compares on every ack. A memory model answers with a latency taken
// from fixed_lat, or from address bits [4:2] when fixed_lat < 0 (0 = never).
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 15;

  typedef struct packed { logic [31:0] data; logic to; } exp_t;
  typedef struct packed { logic rw; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  typedef struct packed { logic port; int unsigned cyc; } ack_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int          n_cmp     = 0;
  int          n_fail    = 0;
  int          fixed_lat = -1;
  bit          spur      = 1'b0;
  bit          to_seen   = 1'b0;
  int unsigned cyc       = 0;
  exp_t        exp_cpu[$];
  exp_t        exp_dbg[$];
  acc_t        acc_log[$];
  ack_t        ack_log[$];
  logic [31:0] store  [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] dflt(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return dflt(a);
  endfunction

  function automatic int lat_of(logic [31:0] a);
    if (fixed_lat >= 0) return fixed_lat;
    return int'(a[4:2]);
  endfunction

  function automatic void preload(logic [31:0] a, logic [31:0] d);
    store[a]  = d;
    shadow[a] = d;
  endfunction

  task automatic drive(input bit port, input bit req, input bit rw, input logic [31:0] a,
                       input logic [31:0] d);
    if (port) begin
      bus.dbg_req = req; bus.dbg_rwbar = rw; bus.dbg_addr = a; bus.dbg_wdata = d;
    end else begin
      bus.cpu_req = req; bus.cpu_rwbar = rw; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Called at posedge+1; returns the ack cycle index relative to the first
  // request cycle, and the number of cycles cpu_stall was seen high.
  task automatic issue(input bit port, input bit rw, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output int stalls);
    exp_t e;
    e.to = (lat_of(a) == 0);
    if (e.to) e.data = '1;
    else if (rw) e.data = model_read(a);
    else begin
      e.data    = '0;
      shadow[a] = d;
    end
    if (port) exp_dbg.push_back(e);
    else exp_cpu.push_back(e);
    drive(port, 1'b1, rw, a, d);
    lat = 0;
    stalls = 0;
    forever begin
      @(negedge CLK);
      if (!port && bus.cpu_stall) stalls++;
      if (port ? bus.dbg_ack : bus.cpu_ack) break;
      lat++;
      if (lat > 100) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ack_wait port=%0d: no ack after %0d cycles, required an ack", port, lat);
        break;
      end
    end
    @(posedge CLK);
    #1;
    drive(port, 1'b0, 1'b1, $urandom, $urandom);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_mem_req"},   32'(bus.mem_req), 0);
    check({tag, "_mem_rwbar"}, 32'(bus.mem_rwbar), 1);
    check({tag, "_mem_addr"},  bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_cpu_ack"},   32'(bus.cpu_ack), 0);
    check({tag, "_dbg_ack"},   32'(bus.dbg_ack), 0);
    check({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    check({tag, "_dbg_rdata"}, bus.dbg_rdata, 0);
    check({tag, "_timeout"},   32'(bus.timeout_err), 0);
  endtask

  task automatic rand_agent(input bit port, input int n);
    logic [31:0] a;
    int l;
    int s;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK);
        #1;
      end
      a      = '0;
      a[8]   = port;
      a[6:5] = 2'($urandom_range(0, 3));
      a[4:2] = 3'($urandom_range(0, 7));
      issue(port, 1'($urandom_range(0, 1)), a, $urandom, l, s);
    end
  endtask

  task automatic score(input bit port, input logic [31:0] rd);
    exp_t e;
    ack_t k;
    k.port = port;
    k.cyc  = cyc;
    ack_log.push_back(k);
    if ((port && exp_dbg.size() == 0) || (!port && exp_cpu.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_ack port=%0d: got ack with rdata %h, required no ack", port, rd);
      return;
    end
    if (port) e = exp_dbg.pop_front();
    else e = exp_cpu.pop_front();
    check(port ? "dbg_rdata" : "cpu_rdata", rd, e.data);
    if (e.to) to_seen = 1'b1;
    check("timeout_err_at_ack", 32'(bus.timeout_err), 32'(to_seen));
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (RESET) to_seen = 1'b0;
      else check("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~bus.cpu_ack));
      check("single_ack", 32'(bus.cpu_ack & bus.dbg_ack), 0);
      if (bus.cpu_ack === 1'b1) score(1'b0, bus.cpu_rdata);
      if (bus.dbg_ack === 1'b1) score(1'b1, bus.dbg_rdata);
    end
  end

  // Memory model.
  initial begin
    int          acc;
    int          l;
    acc_t        cur;
    logic [31:0] a;
    acc = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      bus.mem_ready = 1'b0;
      if (bus.mem_req) begin
        acc++;
        if (acc == 1) begin
          cur.rw    = bus.mem_rwbar;
          cur.addr  = bus.mem_addr;
          cur.wdata = bus.mem_wdata;
          acc_log.push_back(cur);
        end else begin
          check("mem_rwbar_stable", 32'(bus.mem_rwbar), 32'(cur.rw));
          check("mem_addr_stable", bus.mem_addr, cur.addr);
          check("mem_wdata_stable", bus.mem_wdata, cur.wdata);
        end
        l = lat_of(bus.mem_addr);
        if (l != 0 && acc == l) begin
          a = bus.mem_addr;
          bus.mem_ready = 1'b1;
          if (bus.mem_rwbar) begin
            bus.mem_rdata = store.exists(a) ? store[a] : dflt(a);
          end else begin
            store[a]      = bus.mem_wdata;
            bus.mem_rdata = $urandom;
          end
        end
      end else begin
        acc = 0;
        if (spur) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int          lat;
    int          st;
    int          l0;
    int          s0;
    int          l1;
    int          s1;
    logic [31:0] tie_addr [4];
    tie_addr[0] = 32'h200;
    tie_addr[1] = 32'h300;
    tie_addr[2] = 32'h204;
    tie_addr[3] = 32'h304;

    RESET = 1'b1;
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    drive(1'b1, 1'b0, 1'b1, '0, '0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("por");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // CPU read, memory ready in the first ACCESS cycle.
    fixed_lat = 1;
    preload(32'h100, 32'hDEADBEEF);
    ack_log.delete();
    issue(1'b0, 1'b1, 32'h100, '0, lat, st);
    check("rd_latency", lat, 2);
    check("rd_stall_cycles", st, 2);
    check("rd_ack_count", ack_log.size(), 1);
    if (ack_log.size() == 1) check("rd_ack_port", 32'(ack_log[0].port), 0);

    // Both ports held: grants must alternate starting with the CPU.
    do_reset();
    ack_log.delete();
    acc_log.delete();
    fork
      begin
        issue(1'b0, 1'b1, tie_addr[0], '0, l0, s0);
        issue(1'b0, 1'b1, tie_addr[2], '0, l0, s0);
      end
      begin
        issue(1'b1, 1'b1, tie_addr[1], '0, l1, s1);
        issue(1'b1, 1'b1, tie_addr[3], '0, l1, s1);
      end
    join
    check("tie_ack_count", ack_log.size(), 4);
    check("tie_access_count", acc_log.size(), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++) begin
      check($sformatf("tie_owner%0d", i), 32'(ack_log[i].port), 32'(i % 2));
      if (i > 0) check($sformatf("tie_period%0d", i), ack_log[i].cyc - ack_log[i-1].cyc, 3);
    end
    for (int i = 0; i < acc_log.size() && i < 4; i++) begin
      check($sformatf("tie_mem_addr%0d", i), acc_log[i].addr, tie_addr[i]);
    end

    // Debug write, ready in the 4th ACCESS cycle, then read it back.
    fixed_lat = 4;
    acc_log.delete();
    issue(1'b1, 1'b0, 32'h40, 32'h12345678, lat, st);
    check("wr_latency", lat, 5);
    check("wr_access_count", acc_log.size(), 1);
    if (acc_log.size() == 1) begin
      check("wr_mem_rwbar", 32'(acc_log[0].rw), 0);
      check("wr_mem_addr", acc_log[0].addr, 32'h40);
      check("wr_mem_wdata", acc_log[0].wdata, 32'h12345678);
    end
    fixed_lat = 1;
    issue(1'b0, 1'b1, 32'h40, '0, lat, st);

    // Memory never answers: timeout after MW ACCESS cycles.
    fixed_lat = 0;
    issue(1'b0, 1'b1, 32'h80, '0, lat, st);
    check("to_latency", lat, MW + 1);
    fixed_lat = 2;
    issue(1'b0, 1'b1, 32'h84, '0, lat, st);
    check("after_to_latency", lat, 3);
    @(negedge CLK);
    check("to_sticky", 32'(bus.timeout_err), 1);
    @(posedge CLK);
    #1;

    // Reset during the 3rd ACCESS cycle.
    fixed_lat = 0;
    drive(1'b0, 1'b1, 1'b1, 32'h88, '0);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("mid_access_mem_req", 32'(bus.mem_req), 1);
    RESET = 1'b1;
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_vals("mid_rst");
    repeat (3) @(posedge CLK);
    #1;
    fixed_lat = 1;
    issue(1'b0, 1'b1, 32'h8C, '0, lat, st);
    check("post_rst_latency", lat, 2);

    // mem_ready pulses while idle must be ignored.
    ack_log.delete();
    acc_log.delete();
    spur = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("spur_mem_req", 32'(bus.mem_req), 0);
    end
    @(posedge CLK);
    #1;
    spur = 1'b0;
    check("spur_acks", ack_log.size(), 0);
    check("spur_cpu_rdata_hold", bus.cpu_rdata, dflt(32'h8C));
    issue(1'b0, 1'b1, 32'h100, '0, lat, st);
    check("post_spur_latency", lat, 2);

    // Randomized two-port traffic.
    do_reset();
    fixed_lat = -1;
    fork
      rand_agent(1'b0, 40);
      rand_agent(1'b1, 40);
    join
    repeat (3) @(negedge CLK);
    check("cpu_queue_drained", exp_cpu.size(), 0);
    check("dbg_queue_drained", exp_dbg.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
